// File: rtl/inst_line_fetcher.sv
// Memory-side responder for the instruction-buffer fetch handshake: issues one burst read per
// fetch request and assembles the returned beats into a single instruction line.
module inst_line_fetcher #(
   parameter int ADDR_W = 48,
   parameter int BEAT_W = 64,
   parameter int LINE_W = 512
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              pc_index_valid,
   input  logic [ADDR_W-1:0] pc_index,
   input  logic              redirect,
   output logic              pc_index_ready,
   output logic [LINE_W-1:0] pc_read_inst,
   output logic              busy,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_resp_valid,
   input  logic [BEAT_W-1:0] mem_resp_data
);

   localparam int BEATS = LINE_W / BEAT_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [2:0] {IDLE, REQ, RECV, DRAIN, DONE} state_t;

   state_t            state;
   logic              pending_valid;
   logic [ADDR_W-1:0] pending_addr;
   logic [CNT_W-1:0]  beat_cnt;
   logic [LINE_W-1:0] fill_buf;
   logic [LINE_W-1:0] fill_next;
   logic              last_beat;

   // The final beat is merged combinationally so the line can be published on the same edge.
   always_comb begin
      fill_next = fill_buf;
      fill_next[int'(beat_cnt)*BEAT_W +: BEAT_W] = mem_resp_data;
      last_beat = (beat_cnt == LAST_BEAT);
   end

   assign busy = (state != IDLE) | pending_valid;

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         pending_valid  <= 1'b0;
         pending_addr   <= '0;
         beat_cnt       <= '0;
         fill_buf       <= '0;
         pc_read_inst   <= '0;
         pc_index_ready <= 1'b0;
         mem_req_valid  <= 1'b0;
         mem_req_addr   <= '0;
      end else begin
         pc_index_ready <= 1'b0;

         // Outside IDLE a new request only lands in the one-entry pending slot; redirect wipes it.
         if (redirect) begin
            pending_valid <= 1'b0;
         end else if (pc_index_valid && state != IDLE) begin
            pending_valid <= 1'b1;
            pending_addr  <= pc_index;
         end

         case (state)
            IDLE: begin
               if (!redirect) begin
                  if (pending_valid) begin
                     state         <= REQ;
                     mem_req_valid <= 1'b1;
                     mem_req_addr  <= pending_addr;
                     pending_valid <= pc_index_valid;
                     if (pc_index_valid) pending_addr <= pc_index;
                  end else if (pc_index_valid) begin
                     state         <= REQ;
                     mem_req_valid <= 1'b1;
                     mem_req_addr  <= pc_index;
                  end
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  beat_cnt      <= '0;
                  state         <= redirect ? DRAIN : RECV;
               end else if (redirect) begin
                  mem_req_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            RECV: begin
               if (mem_resp_valid) begin
                  fill_buf <= fill_next;
                  beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                  if (last_beat) begin
                     if (redirect) begin
                        state <= IDLE;
                     end else begin
                        state          <= DONE;
                        pc_read_inst   <= fill_next;
                        pc_index_ready <= 1'b1;
                     end
                  end else if (redirect) begin
                     state <= DRAIN;
                  end
               end else if (redirect) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (mem_resp_valid) begin
                  beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                  if (last_beat) state <= IDLE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_line_fetcher.sv
// Directed self-checking bench for inst_line_fetcher (default 48/64/512 configuration).
module tb_inst_line_fetcher;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         pc_index_valid = 1'b0;
   logic [47:0]  pc_index = '0;
   logic         redirect = 1'b0;
   logic         pc_index_ready;
   logic [511:0] pc_read_inst;
   logic         busy;
   logic         mem_req_valid;
   logic         mem_req_ready = 1'b1;
   logic [47:0]  mem_req_addr;
   logic         mem_resp_valid = 1'b0;
   logic [63:0]  mem_resp_data = '0;

   int tests = 0;
   int failed = 0;

   inst_line_fetcher dut (
      .clock          (clock),
      .reset          (reset),
      .pc_index_valid (pc_index_valid),
      .pc_index       (pc_index),
      .redirect       (redirect),
      .pc_index_ready (pc_index_ready),
      .pc_read_inst   (pc_read_inst),
      .busy           (busy),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data)
   );

   always #5 clock = ~clock;

   function automatic logic [511:0] expLine(input logic [63:0] base);
      logic [511:0] l;
      for (int k = 0; k < 8; k++) l[k*64 +: 64] = base + 64'(k);
      return l;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [47:0] pc, input logic rd,
                                input logic rv, input logic [63:0] rdata);
      pc_index_valid = v;
      pc_index       = pc;
      redirect       = rd;
      mem_resp_valid = rv;
      mem_resp_data  = rdata;
   endtask

   task automatic checkOutput(input string tag, input logic [511:0] observed,
                              input logic [511:0] expected);
      tests++;
      assert (observed === expected) else begin
         failed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_ready"}, 512'(pc_index_ready), 512'(0));
      checkOutput({tag, "_reqv"}, 512'(mem_req_valid), 512'(0));
      checkOutput({tag, "_busy"}, 512'(busy), 512'(0));
      checkOutput({tag, "_inst"}, pc_read_inst, 512'(0));
      checkOutput({tag, "_addr"}, 512'(mem_req_addr), 512'(0));
   endtask

   // Drives 8 beats base+k back to back; ready must stay low until after the last one.
   task automatic sendLine(input string tag, input logic [63:0] base, input logic expReady,
                           input logic [511:0] expInst);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b0, '0, 1'b0, 1'b1, base + 64'(k));
         step();
         if (k < 7) checkOutput({tag, "_early_ready"}, 512'(pc_index_ready), 512'(0));
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
      checkOutput({tag, "_ready"}, 512'(pc_index_ready), 512'(expReady));
      checkOutput({tag, "_inst"}, pc_read_inst, expInst);
   endtask

   task automatic issueRequest(input string tag, input logic [47:0] addr);
      applyStimulus(1'b1, addr, 1'b0, 1'b0, '0);
      step();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
      checkOutput({tag, "_reqv"}, 512'(mem_req_valid), 512'(1));
      checkOutput({tag, "_addr"}, 512'(mem_req_addr), 512'(addr));
   endtask

   initial begin
      // 1) reset, basic fetch
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      checkReset("t1_reset");
      issueRequest("t1", 48'h1000);
      checkOutput("t1_busy", 512'(busy), 512'(1));
      step();
      checkOutput("t1_reqv_drop", 512'(mem_req_valid), 512'(0));
      sendLine("t1", 64'h0, 1'b1, expLine(64'h0));
      step();
      checkOutput("t1_pulse_end", 512'(pc_index_ready), 512'(0));
      checkOutput("t1_idle_busy", 512'(busy), 512'(0));
      checkOutput("t1_inst_held", pc_read_inst, expLine(64'h0));

      // 2) arbiter stalls 5 cycles; stray beats during REQ must be ignored
      mem_req_ready = 1'b0;
      issueRequest("t2", 48'h2000);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, '0, 1'b0, 1'b1, 64'hDEAD);
         step();
         checkOutput("t2_stall_reqv", 512'(mem_req_valid), 512'(1));
         checkOutput("t2_stall_addr", 512'(mem_req_addr), 512'(48'h2000));
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
      mem_req_ready = 1'b1;
      step();
      checkOutput("t2_reqv_drop", 512'(mem_req_valid), 512'(0));
      sendLine("t2", 64'h200, 1'b1, expLine(64'h200));
      step();

      // 3) two requests while busy: only the latest survives
      issueRequest("t3", 48'h1000);
      step();
      for (int k = 0; k < 8; k++) begin
         applyStimulus(k == 3 || k == 5, (k == 3) ? 48'h2000 : 48'h3000, 1'b0, 1'b1,
                       64'h100 + 64'(k));
         step();
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
      checkOutput("t3_ready", 512'(pc_index_ready), 512'(1));
      checkOutput("t3_inst", pc_read_inst, expLine(64'h100));
      step();
      checkOutput("t3_pend_busy", 512'(busy), 512'(1));
      checkOutput("t3_pend_reqv", 512'(mem_req_valid), 512'(0));
      step();
      checkOutput("t3_next_reqv", 512'(mem_req_valid), 512'(1));
      checkOutput("t3_next_addr", 512'(mem_req_addr), 512'(48'h3000));
      step();
      sendLine("t3b", 64'h300, 1'b1, expLine(64'h300));
      step();

      // 4) redirect at beat 4, new request one cycle later
      issueRequest("t4", 48'h1000);
      step();
      for (int k = 0; k < 8; k++) begin
         applyStimulus(k == 5, 48'h4000, k == 4, 1'b1, 64'h400 + 64'(k));
         step();
         checkOutput("t4_no_ready", 512'(pc_index_ready), 512'(0));
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
      checkOutput("t4_inst_unchanged", pc_read_inst, expLine(64'h300));
      checkOutput("t4_drain_reqv", 512'(mem_req_valid), 512'(0));
      checkOutput("t4_pend_busy", 512'(busy), 512'(1));
      step();
      checkOutput("t4_next_reqv", 512'(mem_req_valid), 512'(1));
      checkOutput("t4_next_addr", 512'(mem_req_addr), 512'(48'h4000));
      step();
      sendLine("t4b", 64'h500, 1'b1, expLine(64'h500));
      step();

      // 5) redirect beats a same-cycle request in IDLE; redirect in REQ drops the request
      applyStimulus(1'b1, 48'h5000, 1'b1, 1'b0, '0);
      step();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
      checkOutput("t5_idle_reqv", 512'(mem_req_valid), 512'(0));
      checkOutput("t5_idle_busy", 512'(busy), 512'(0));
      step();
      checkOutput("t5_idle_reqv2", 512'(mem_req_valid), 512'(0));
      mem_req_ready = 1'b0;
      issueRequest("t5", 48'h6000);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
      step();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
      checkOutput("t5_req_drop", 512'(mem_req_valid), 512'(0));
      checkOutput("t5_req_busy", 512'(busy), 512'(0));
      mem_req_ready = 1'b1;
      step();
      checkOutput("t5_req_stay", 512'(mem_req_valid), 512'(0));

      // 6) reset during RECV, then stray beats
      issueRequest("t6", 48'h7000);
      step();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, '0, 1'b0, 1'b1, 64'h700 + 64'(k));
         reset = (k == 2);
         step();
      end
      reset = 1'b0;
      checkReset("t6_reset");
      for (int k = 3; k < 8; k++) begin
         applyStimulus(1'b0, '0, 1'b0, 1'b1, 64'h700 + 64'(k));
         step();
         checkOutput("t6_stray_busy", 512'(busy), 512'(0));
         checkOutput("t6_stray_ready", 512'(pc_index_ready), 512'(0));
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
      issueRequest("t6b", 48'h8000);
      step();
      sendLine("t6b", 64'h800, 1'b1, expLine(64'h800));
      step();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
